// File: rtl/iomem_gpio_pkg.sv
// Shared definitions for the iomem GPIO peripheral: register offsets,
// address field positions, bus handshake states and a strobe helper.
package iomem_gpio_pkg;

    // Address fields: [31:24] selects the peripheral, [4:2] picks a register.
    localparam int ADDR_BASE_MSB = 31;
    localparam int ADDR_BASE_LSB = 24;
    localparam int ADDR_REG_MSB  = 4;
    localparam int ADDR_REG_LSB  = 2;

    // Register word offsets (byte offset >> 2).
    localparam logic [2:0] REG_OUT      = 3'd0;
    localparam logic [2:0] REG_OE       = 3'd1;
    localparam logic [2:0] REG_IN       = 3'd2;
    localparam logic [2:0] REG_SET      = 3'd3;
    localparam logic [2:0] REG_CLR      = 3'd4;
    localparam logic [2:0] REG_TGL      = 3'd5;
    localparam logic [2:0] REG_IRQ_EN   = 3'd6;
    localparam logic [2:0] REG_IRQ_STAT = 3'd7;

    // Bus handshake: one request accepted, acknowledged for exactly one cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    // Expand the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strobe_mask(input logic [3:0] wstrb);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{wstrb[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/iomem_gpio_sync.sv
// Per-bit flop-chain synchroniser for asynchronous pad inputs.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the pad value through STAGES flops; the oldest stage is the safe copy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: output/enable registers,
// synchronised inputs, atomic SET/CLR/TGL and sticky rising-edge interrupts.
module iomem_gpio
    import iomem_gpio_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = 8'h03,
    parameter int         NPINS       = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oe,
    output logic             irq
);

    bus_state_t       state;
    bus_state_t       state_next;
    logic             select;
    logic             write;
    logic [2:0]       reg_sel;
    logic [31:0]      full_mask;
    logic [NPINS-1:0] bit_mask;
    logic [NPINS-1:0] wdata_masked;
    logic [NPINS-1:0] out_reg;
    logic [NPINS-1:0] oe_reg;
    logic [NPINS-1:0] irq_en_reg;
    logic [NPINS-1:0] irq_stat_reg;
    logic [NPINS-1:0] out_next;
    logic [NPINS-1:0] oe_next;
    logic [NPINS-1:0] irq_en_next;
    logic [NPINS-1:0] irq_stat_next;
    logic [NPINS-1:0] sync_in;
    logic [NPINS-1:0] prev_in;
    logic [NPINS-1:0] rise;
    logic [31:0]      read_value;
    logic             unused_bits;

    // Address aliases and data bits above NPINS are deliberately ignored.
    assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, full_mask};

    // A request is taken only while no acknowledge is outstanding, so ready never repeats.
    assign select = iomem_valid && !iomem_ready &&
                    (iomem_addr[ADDR_BASE_MSB:ADDR_BASE_LSB] == BASE_ADDR);
    assign write        = select && (iomem_wstrb != 4'b0000);
    assign reg_sel      = iomem_addr[ADDR_REG_MSB:ADDR_REG_LSB];
    assign full_mask    = strobe_mask(iomem_wstrb);
    assign bit_mask     = full_mask[NPINS-1:0];
    assign wdata_masked = iomem_wdata[NPINS-1:0] & bit_mask;

    gpio_sync #(
        .WIDTH  (NPINS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (gpio_in),
        .q      (sync_in)
    );

    assign rise = sync_in & ~prev_in;

    // Handshake sequencing: accept in IDLE, acknowledge for one cycle, return.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (select) state_next = ST_ACK;
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Read mux sees the registers before this cycle's write lands.
    always_comb begin
        read_value = '0;
        case (reg_sel)
            REG_OUT:      read_value[NPINS-1:0] = out_reg;
            REG_OE:       read_value[NPINS-1:0] = oe_reg;
            REG_IN:       read_value[NPINS-1:0] = sync_in;
            REG_IRQ_EN:   read_value[NPINS-1:0] = irq_en_reg;
            REG_IRQ_STAT: read_value[NPINS-1:0] = irq_stat_reg;
            default:      read_value = '0;
        endcase
    end

    // Register update rules; a new rising edge beats a same-cycle clear.
    always_comb begin
        out_next      = out_reg;
        oe_next       = oe_reg;
        irq_en_next   = irq_en_reg;
        irq_stat_next = irq_stat_reg;
        if (write) begin
            case (reg_sel)
                REG_OUT:      out_next      = (out_reg & ~bit_mask) | wdata_masked;
                REG_OE:       oe_next       = (oe_reg & ~bit_mask) | wdata_masked;
                REG_SET:      out_next      = out_reg | wdata_masked;
                REG_CLR:      out_next      = out_reg & ~wdata_masked;
                REG_TGL:      out_next      = out_reg ^ wdata_masked;
                REG_IRQ_EN:   irq_en_next   = (irq_en_reg & ~bit_mask) | wdata_masked;
                REG_IRQ_STAT: irq_stat_next = irq_stat_reg & ~wdata_masked;
                default:      out_next      = out_reg;
            endcase
        end
        irq_stat_next = irq_stat_next | rise;
    end

    // State, register file, edge history and captured read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            out_reg      <= '0;
            oe_reg       <= '0;
            irq_en_reg   <= '0;
            irq_stat_reg <= '0;
            prev_in      <= '0;
            iomem_rdata  <= '0;
        end else begin
            state        <= state_next;
            out_reg      <= out_next;
            oe_reg       <= oe_next;
            irq_en_reg   <= irq_en_next;
            irq_stat_reg <= irq_stat_next;
            prev_in      <= sync_in;
            if (select) begin
                iomem_rdata <= read_value;
            end
        end
    end

    assign iomem_ready = (state == ST_ACK);
    assign gpio_out    = out_reg;
    assign gpio_oe     = oe_reg;
    assign irq         = |(irq_stat_reg & irq_en_reg);

endmodule

// File: tb/tb_iomem_gpio.sv
// Self-checking bench for iomem_gpio: directed scenarios followed by random
// bus traffic and pin activity, compared against a behavioural register model.
module tb_iomem_gpio;

    localparam int NPINS       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HIST_DEPTH  = 8192;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic [7:0]  gpio_in = 8'h00;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Model state: pad value seen at every edge, plus the architectural registers.
    logic [7:0]  hist [0:HIST_DEPTH-1];
    int          cyc = 0;
    logic [7:0]  m_out = 8'h00;
    logic [7:0]  m_oe = 8'h00;
    logic [7:0]  m_ien = 8'h00;
    logic [7:0]  m_stat = 8'h00;
    logic [31:0] m_rdata = 32'h0;

    iomem_gpio #(
        .BASE_ADDR   (8'h03),
        .NPINS       (NPINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hist_at(input int i);
        return (i < 0) ? 8'h00 : hist[i];
    endfunction

    // Address for a register offset with random alias bits in the ignored fields.
    function automatic logic [31:0] addr_of(input int off);
        logic [31:0] a;
        a = $urandom;
        a[31:24] = 8'h03;
        a[4:2]   = off[2:0];
        return a;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and update the model. A pad value first sampled at edge k is
    // readable through IN and can raise a flag SYNC_STAGES edges later.
    task automatic tick(input bit bus_edge);
        logic [7:0] synced;
        logic [7:0] older;
        logic [7:0] m8;
        logic [7:0] d;
        int         off;
        @(posedge clk);
        hist[cyc % HIST_DEPTH] = resetn ? gpio_in : 8'h00;
        synced = hist_at(cyc - SYNC_STAGES);
        older  = hist_at(cyc - SYNC_STAGES - 1);
        if (!resetn) begin
            m_out = 0; m_oe = 0; m_ien = 0; m_stat = 0; m_rdata = 0;
        end else begin
            if (bus_edge) begin
                off = int'(iomem_addr[4:2]);
                m8  = {8{iomem_wstrb[0]}};
                d   = iomem_wdata[7:0] & m8;
                case (off)
                    0:       m_rdata = {24'h0, m_out};
                    1:       m_rdata = {24'h0, m_oe};
                    2:       m_rdata = {24'h0, synced};
                    6:       m_rdata = {24'h0, m_ien};
                    7:       m_rdata = {24'h0, m_stat};
                    default: m_rdata = 32'h0;
                endcase
                if (iomem_wstrb != 4'h0) begin
                    case (off)
                        0:       m_out  = (m_out & ~m8) | d;
                        1:       m_oe   = (m_oe & ~m8) | d;
                        3:       m_out  = m_out | d;
                        4:       m_out  = m_out & ~d;
                        5:       m_out  = m_out ^ d;
                        6:       m_ien  = (m_ien & ~m8) | d;
                        7:       m_stat = m_stat & ~d;
                        default: ;
                    endcase
                end
            end
            m_stat = m_stat | (synced & ~older);
        end
        cyc++;
        #1;
    endtask

    // One complete bus transfer: request, single-cycle acknowledge, release.
    task automatic apply_stimulus(input string tag, input logic [31:0] addr,
                                  input logic [3:0] wstrb, input logic [31:0] wdata);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        tick(1'b1);
        check_output({tag, "_ready"}, {31'h0, iomem_ready}, 32'h1);
        check_output({tag, "_rdata"}, iomem_rdata, m_rdata);
        check_output({tag, "_out"},   {24'h0, gpio_out}, {24'h0, m_out});
        check_output({tag, "_oe"},    {24'h0, gpio_oe},  {24'h0, m_oe});
        check_output({tag, "_irq"},   {31'h0, irq}, {31'h0, |(m_stat & m_ien)});
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        tick(1'b0);
        check_output({tag, "_ready_drop"}, {31'h0, iomem_ready}, 32'h0);
    endtask

    initial begin
        int off;
        logic [3:0] ws;

        $display("[TB] reset");
        resetn = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0);
        check_output("rst_ready", {31'h0, iomem_ready}, 32'h0);
        check_output("rst_rdata", iomem_rdata, 32'h0);
        check_output("rst_out",   {24'h0, gpio_out}, 32'h0);
        check_output("rst_oe",    {24'h0, gpio_oe}, 32'h0);
        check_output("rst_irq",   {31'h0, irq}, 32'h0);
        resetn = 1'b1;
        tick(1'b0);

        $display("[TB] read all offsets after reset");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus("rd_reset", addr_of(i), 4'h0, 32'hFFFF_FFFF);
            check_output("rd_reset_zero", iomem_rdata, 32'h0);
        end

        $display("[TB] OUT/SET/CLR/TGL sequence");
        apply_stimulus("wr_out", addr_of(0), 4'hF, 32'h0000_00A5);
        check_output("out_a5", {24'h0, gpio_out}, 32'hA5);
        apply_stimulus("set", addr_of(3), 4'hF, 32'h0000_000F);
        check_output("out_af", {24'h0, gpio_out}, 32'hAF);
        apply_stimulus("clr", addr_of(4), 4'hF, 32'h0000_0081);
        check_output("out_2e", {24'h0, gpio_out}, 32'h2E);
        apply_stimulus("tgl", addr_of(5), 4'hF, 32'h0000_00FF);
        check_output("out_d1", {24'h0, gpio_out}, 32'hD1);
        apply_stimulus("rd_out", addr_of(0), 4'h0, 32'h0);
        check_output("rd_out_d1", iomem_rdata, 32'h0000_00D1);
        apply_stimulus("rd_set", addr_of(3), 4'h0, 32'h0);
        check_output("rd_set_zero", iomem_rdata, 32'h0);

        $display("[TB] OE byte strobe");
        apply_stimulus("wr_oe", addr_of(1), 4'h1, 32'hFFFF_FF3C);
        check_output("oe_3c", {24'h0, gpio_oe}, 32'h3C);
        apply_stimulus("rd_oe", addr_of(1), 4'h0, 32'h0);
        check_output("rd_oe_3c", iomem_rdata, 32'h0000_003C);
        apply_stimulus("wr_oe_hi", addr_of(1), 4'hE, 32'h0000_0000);
        check_output("oe_hi_ignored", {24'h0, gpio_oe}, 32'h3C);

        $display("[TB] input path and interrupts");
        gpio_in = 8'h81;
        apply_stimulus("rd_in_early", addr_of(2), 4'h0, 32'h0);
        check_output("in_not_yet", iomem_rdata, 32'h0);
        apply_stimulus("rd_in", addr_of(2), 4'h0, 32'h0);
        check_output("in_81", iomem_rdata, 32'h0000_0081);
        apply_stimulus("rd_stat", addr_of(7), 4'h0, 32'h0);
        check_output("stat_81", iomem_rdata, 32'h0000_0081);
        check_output("irq_masked", {31'h0, irq}, 32'h0);
        apply_stimulus("wr_ien", addr_of(6), 4'hF, 32'h0000_0001);
        check_output("irq_on", {31'h0, irq}, 32'h1);
        apply_stimulus("w1c", addr_of(7), 4'hF, 32'h0000_0001);
        check_output("irq_off", {31'h0, irq}, 32'h0);
        apply_stimulus("rd_stat2", addr_of(7), 4'h0, 32'h0);
        check_output("stat_80", iomem_rdata, 32'h0000_0080);

        $display("[TB] rise coincident with clear");
        gpio_in = 8'h89;
        for (int i = 0; i < 4; i++) tick(1'b0);
        gpio_in = 8'h81;
        for (int i = 0; i < 4; i++) tick(1'b0);
        gpio_in = 8'h89;
        tick(1'b0);
        tick(1'b0);
        apply_stimulus("w1c_race", addr_of(7), 4'hF, 32'h0000_0008);
        apply_stimulus("rd_stat3", addr_of(7), 4'h0, 32'h0);
        check_output("stat_bit3_kept", {31'h0, iomem_rdata[3]}, 32'h1);

        $display("[TB] foreign address and alias");
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            check_output("foreign_no_ready", {31'h0, iomem_ready}, 32'h0);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        check_output("foreign_out", {24'h0, gpio_out}, {24'h0, m_out});
        tick(1'b0);
        apply_stimulus("alias_rd", 32'h03FF_FFE0, 4'h0, 32'h0);
        check_output("alias_out_d1", iomem_rdata, 32'h0000_00D1);

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            off = int'($urandom_range(0, 7));
            ws  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            apply_stimulus("rand", addr_of(off), ws, $urandom);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick(1'b0);
        end
        apply_stimulus("final_stat", addr_of(7), 4'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
